// File: rtl/writeback_stage.sv
// MEM/WB pipeline latch with writeback data select, load extraction and sticky halt.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage #(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic        mem_reg_wen,
   input  logic [4:0]  mem_wsel,
   input  logic [1:0]  mem_wb_sel,
   input  logic [1:0]  mem_ld_size,
   input  logic        mem_ld_sign,
   input  logic [31:0] mem_alu_res,
   input  logic [31:0] mem_dmem_rd,
   input  logic [31:0] mem_npc,
   input  logic [15:0] mem_imm16,
   input  logic        mem_halt,
   output logic        rf_wen,
   output logic [4:0]  rf_wsel,
   output logic [31:0] rf_wdat,
   output logic        wb_valid,
   output logic        halt
`ifdef WB_RETIRE_COUNT_EN
   ,
   output logic [CNT_W-1:0] retire_count
`endif
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   logic        l_reg_wen;
   logic [4:0]  l_wsel;
   logic [1:0]  l_wb_sel;
   logic [1:0]  l_ld_size;
   logic        l_ld_sign;
   logic [31:0] l_alu_res;
   logic [31:0] l_dmem_rd;
   logic [31:0] l_npc;
   logic [15:0] l_imm16;
   logic        l_halt;
   logic        halt_next;

   // Halt takes effect on the same edge the HALT retires, so the instruction
   // behind it is already squashed into a bubble.
   assign halt_next = halt | (wb_valid & l_halt);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         wb_valid  <= 1'b0;
         l_reg_wen <= 1'b0;
         l_wsel    <= 5'd0;
         l_wb_sel  <= 2'd0;
         l_ld_size <= 2'd0;
         l_ld_sign <= 1'b0;
         l_alu_res <= 32'd0;
         l_dmem_rd <= 32'd0;
         l_npc     <= 32'd0;
         l_imm16   <= 16'd0;
         l_halt    <= 1'b0;
         halt      <= 1'b0;
      end else begin
         halt <= halt_next;
         if (flush || halt_next) begin
            wb_valid  <= 1'b0;
            l_reg_wen <= 1'b0;
            l_wsel    <= 5'd0;
            l_wb_sel  <= 2'd0;
            l_ld_size <= 2'd0;
            l_ld_sign <= 1'b0;
            l_alu_res <= 32'd0;
            l_dmem_rd <= 32'd0;
            l_npc     <= 32'd0;
            l_imm16   <= 16'd0;
            l_halt    <= 1'b0;
         end else if (!stall) begin
            wb_valid  <= mem_valid;
            l_reg_wen <= mem_reg_wen;
            l_wsel    <= mem_wsel;
            l_wb_sel  <= mem_wb_sel;
            l_ld_size <= mem_ld_size;
            l_ld_sign <= mem_ld_sign;
            l_alu_res <= mem_alu_res;
            l_dmem_rd <= mem_dmem_rd;
            l_npc     <= mem_npc;
            l_imm16   <= mem_imm16;
            l_halt    <= mem_halt;
         end
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST)
         retire_count <= '0;
      else if (wb_valid && !stall)
         retire_count <= retire_count + CNT_W'(1);
   end
`endif

   logic [15:0] ld_half;
   logic [7:0]  ld_byte;
   logic [31:0] ld_data;

   // Big-endian: byte offset 0 is the most significant byte of the word.
   always_comb begin
      ld_half = l_alu_res[1] ? l_dmem_rd[15:0] : l_dmem_rd[31:16];
      ld_byte = 8'd0;
      case (l_alu_res[1:0])
         2'd0: ld_byte = l_dmem_rd[31:24];
         2'd1: ld_byte = l_dmem_rd[23:16];
         2'd2: ld_byte = l_dmem_rd[15:8];
         default: ld_byte = l_dmem_rd[7:0];
      endcase
      case (l_ld_size)
         2'b01:   ld_data = l_ld_sign ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
         2'b10:   ld_data = l_ld_sign ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
         default: ld_data = l_dmem_rd;
      endcase
   end

   always_comb begin
      case (l_wb_sel)
         SEL_ALU:  rf_wdat = l_alu_res;
         SEL_LOAD: rf_wdat = ld_data;
         SEL_LINK: rf_wdat = l_npc;
         default:  rf_wdat = {l_imm16, 16'h0000};
      endcase
   end

   assign rf_wen  = wb_valid & l_reg_wen & (l_wsel != 5'd0) & ~l_halt;
   assign rf_wsel = l_wsel;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the WB latch.
module tb_writeback_stage;

   localparam int TB_CNT_W = 4;

   logic        clk, nRST, stall, flush;
   logic        mem_valid, mem_reg_wen, mem_ld_sign, mem_halt;
   logic [4:0]  mem_wsel;
   logic [1:0]  mem_wb_sel, mem_ld_size;
   logic [31:0] mem_alu_res, mem_dmem_rd, mem_npc;
   logic [15:0] mem_imm16;
   logic        rf_wen, wb_valid, halt;
   logic [4:0]  rf_wsel;
   logic [31:0] rf_wdat;
`ifdef WB_RETIRE_COUNT_EN
   logic [TB_CNT_W-1:0] retire_count;
`endif

   writeback_stage #(.CNT_W(TB_CNT_W)) dut (
      .clk(clk), .nRST(nRST), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_reg_wen(mem_reg_wen), .mem_wsel(mem_wsel),
      .mem_wb_sel(mem_wb_sel), .mem_ld_size(mem_ld_size), .mem_ld_sign(mem_ld_sign),
      .mem_alu_res(mem_alu_res), .mem_dmem_rd(mem_dmem_rd), .mem_npc(mem_npc),
      .mem_imm16(mem_imm16), .mem_halt(mem_halt),
      .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
      .wb_valid(wb_valid), .halt(halt)
`ifdef WB_RETIRE_COUNT_EN
      , .retire_count(retire_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        valid;
      logic        reg_wen;
      logic [4:0]  wsel;
      logic [1:0]  wb_sel;
      logic [1:0]  ld_size;
      logic        ld_sign;
      logic [31:0] alu;
      logic [31:0] dmem;
      logic [31:0] npc;
      logic [15:0] imm;
      logic        hlt;
   } instr_t;

   instr_t      m_lat;
   bit          m_halted;
   int unsigned m_cnt;

   function automatic logic [31:0] model_wdat(instr_t i);
      logic [31:0] raw, mask;
      int off;
      off = int'(i.alu[1:0]);
      case (i.wb_sel)
         2'd0: return i.alu;
         2'd2: return i.npc;
         2'd3: return {i.imm, 16'h0000};
         default: begin
            if (i.ld_size == 2'd2) begin
               mask = 32'hFF;
               raw  = (i.dmem >> (8 * (3 - off))) & mask;
            end else if (i.ld_size == 2'd1) begin
               mask = 32'hFFFF;
               raw  = (i.dmem >> ((off >= 2) ? 0 : 16)) & mask;
            end else begin
               mask = 32'hFFFF_FFFF;
               raw  = i.dmem;
            end
            if (i.ld_sign && (mask != 32'hFFFF_FFFF) && ((raw & ((mask >> 1) + 1)) != 0))
               raw = raw | ~mask;
            return raw;
         end
      endcase
   endfunction

   function automatic logic [39:0] model_out();
      logic wen;
      wen = m_lat.valid && m_lat.reg_wen && (m_lat.wsel != 0) && !m_lat.hlt;
      return {wen, m_lat.wsel, model_wdat(m_lat), m_lat.valid, m_halted};
   endfunction

   function automatic logic [39:0] dut_out();
      return {rf_wen, rf_wsel, rf_wdat, wb_valid, halt};
   endfunction

   task automatic drive(input logic v, input logic rw, input logic [4:0] ws, input logic [1:0] sel,
                        input logic [1:0] sz, input logic sg, input logic [31:0] alu,
                        input logic [31:0] dm, input logic [31:0] npc, input logic [15:0] imm,
                        input logic h);
      mem_valid = v; mem_reg_wen = rw; mem_wsel = ws; mem_wb_sel = sel;
      mem_ld_size = sz; mem_ld_sign = sg; mem_alu_res = alu; mem_dmem_rd = dm;
      mem_npc = npc; mem_imm16 = imm; mem_halt = h;
   endtask

   // Advance the model by one posedge using the current inputs, then clock the DUT.
   task automatic tick();
      instr_t cur;
      bit hnext;
      cur = '{mem_valid, mem_reg_wen, mem_wsel, mem_wb_sel, mem_ld_size, mem_ld_sign,
              mem_alu_res, mem_dmem_rd, mem_npc, mem_imm16, mem_halt};
      hnext = m_halted || (m_lat.valid && m_lat.hlt);
      if (m_lat.valid && !stall) m_cnt++;
      if (flush || hnext) m_lat = '0;
      else if (!stall) m_lat = cur;
      m_halted = hnext;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_lat = '0; m_halted = 0; m_cnt = 0;
   endtask

   task automatic do_reset();
      stall = 0; flush = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nRST = 0;
      #3;
      model_clear();
      nRST = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nRST = 0; stall = 0; flush = 0;
      drive(1, 1, 5'd3, 2'd0, 2'd0, 0, 32'hAAAA_5555, 0, 0, 0, 0);
      #2;
      n_checks++;
      if (dut_out() !== 40'd0) begin
         n_fail++; $display("FAIL reset_initial: got %h expected 0", dut_out());
      end
      @(posedge clk); #1;
      n_checks++;
      if (dut_out() !== 40'd0) begin
         n_fail++; $display("FAIL reset_held_clock: got %h expected 0", dut_out());
      end
      do_reset();
   endtask

   task automatic test_alu();
      drive(1, 1, 5'd5, 2'd0, 2'd0, 0, 32'hDEAD_BEEF, 32'h0, 32'h0, 16'h0, 0);
      tick();
      n_checks++;
      if ({rf_wen, rf_wsel, rf_wdat} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL alu_op: got wen=%b wsel=%0d wdat=%h expected 1/5/deadbeef", rf_wen, rf_wsel, rf_wdat);
      end
   endtask

   task automatic test_load();
      drive(1, 1, 5'd6, 2'd1, 2'd2, 1, 32'h1000_0001, 32'h1280_3456, 0, 0, 0);
      tick();
      n_checks++;
      if (rf_wdat !== 32'hFFFF_FF80 || rf_wen !== 1'b1) begin
         n_fail++; $display("FAIL lb_sign: got wdat=%h wen=%b expected ffffff80/1", rf_wdat, rf_wen);
      end
      drive(1, 1, 5'd6, 2'd1, 2'd1, 0, 32'h1000_0002, 32'h1280_3456, 0, 0, 0);
      tick();
      n_checks++;
      if (rf_wdat !== 32'h0000_3456) begin
         n_fail++; $display("FAIL lhu_off2: got %h expected 00003456", rf_wdat);
      end
      drive(1, 1, 5'd6, 2'd1, 2'd1, 1, 32'h1000_0001, 32'h9280_3456, 0, 0, 0);
      tick();
      n_checks++;
      if (rf_wdat !== 32'hFFFF_9280) begin
         n_fail++; $display("FAIL lh_off1: got %h expected ffff9280", rf_wdat);
      end
   endtask

   task automatic test_wen_and_sel();
      drive(1, 1, 5'd0, 2'd0, 2'd0, 0, 32'h1234, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (rf_wen !== 1'b0) begin
         n_fail++; $display("FAIL wsel0_wen: got %b expected 0", rf_wen);
      end
      drive(0, 1, 5'd4, 2'd0, 2'd0, 0, 32'h1234, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (rf_wen !== 1'b0 || wb_valid !== 1'b0) begin
         n_fail++; $display("FAIL invalid_wen: got wen=%b valid=%b expected 0/0", rf_wen, wb_valid);
      end
      drive(1, 1, 5'd8, 2'd3, 2'd0, 0, 32'h0, 0, 0, 16'h1234, 0);
      tick();
      n_checks++;
      if (rf_wdat !== 32'h1234_0000 || rf_wen !== 1'b1) begin
         n_fail++; $display("FAIL lui: got wdat=%h wen=%b expected 12340000/1", rf_wdat, rf_wen);
      end
      drive(1, 1, 5'd31, 2'd2, 2'd0, 0, 32'h5555, 0, 32'h40, 0, 0);
      tick();
      n_checks++;
      if (rf_wdat !== 32'h0000_0040 || rf_wsel !== 5'd31) begin
         n_fail++; $display("FAIL link: got wdat=%h wsel=%0d expected 00000040/31", rf_wdat, rf_wsel);
      end
   endtask

   task automatic test_stall_flush();
      drive(1, 1, 5'd7, 2'd0, 2'd0, 0, 32'h1111_2222, 0, 0, 0, 0);
      tick();
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 5'd9 + 5'(k), 2'd2, 2'd0, 0, 32'h0, 0, 32'h900 + 32'(k), 0, 0);
         tick();
         n_checks++;
         if ({rf_wen, rf_wsel, rf_wdat, wb_valid} !== {1'b1, 5'd7, 32'h1111_2222, 1'b1}) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got wen=%b wsel=%0d wdat=%h expected 1/7/11112222", k, rf_wen, rf_wsel, rf_wdat);
         end
      end
      stall = 0;
      tick();
      n_checks++;
      if (rf_wsel !== 5'd11 || rf_wdat !== 32'h902) begin
         n_fail++; $display("FAIL stall_release: got wsel=%0d wdat=%h expected 11/00000902", rf_wsel, rf_wdat);
      end
      stall = 1; flush = 1;
      tick();
      stall = 0; flush = 0;
      n_checks++;
      if (wb_valid !== 1'b0 || rf_wen !== 1'b0) begin
         n_fail++; $display("FAIL flush_stall: got valid=%b wen=%b expected 0/0", wb_valid, rf_wen);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         drive(($urandom_range(0, 4) != 0), $urandom_range(0, 1), 5'($urandom), 2'($urandom),
               2'($urandom), $urandom_range(0, 1), $urandom, $urandom, $urandom, 16'($urandom), 0);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         tick();
         n_checks++;
         if (dut_out() !== model_out()) begin
            n_fail++; $display("FAIL random[%0d]: got %h expected %h", k, dut_out(), model_out());
         end
`ifdef WB_RETIRE_COUNT_EN
         n_checks++;
         if (retire_count !== TB_CNT_W'(m_cnt)) begin
            n_fail++; $display("FAIL random_count[%0d]: got %0d expected %0d", k, retire_count, TB_CNT_W'(m_cnt));
         end
`endif
      end
      stall = 0; flush = 0;
   endtask

   task automatic test_halt();
      do_reset();
      drive(1, 0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1);
      tick();
      n_checks++;
      if (wb_valid !== 1'b1 || halt !== 1'b0 || rf_wen !== 1'b0) begin
         n_fail++; $display("FAIL halt_in_wb: got valid=%b halt=%b wen=%b expected 1/0/0", wb_valid, halt, rf_wen);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 5'd3 + 5'(k), 2'd0, 2'd0, 0, 32'hCAFE_0000 + 32'(k), 0, 0, 0, 0);
         tick();
         n_checks++;
         if (halt !== 1'b1 || rf_wen !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_after[%0d]: got halt=%b wen=%b valid=%b expected 1/0/0", k, halt, rf_wen, wb_valid);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1, 1, 5'd9, 2'd0, 2'd0, 0, 32'h0BAD_F00D, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (rf_wen !== 1'b1 || rf_wdat !== 32'h0BAD_F00D) begin
         n_fail++; $display("FAIL pre_async: got wen=%b wdat=%h expected 1/0badf00d", rf_wen, rf_wdat);
      end
      #2 nRST = 0;
      #1;
      n_checks++;
      if (dut_out() !== 40'd0) begin
         n_fail++; $display("FAIL async_reset: got %h expected 0", dut_out());
      end
      model_clear();
      #1 nRST = 1;
      @(posedge clk); #1;
      model_clear();
   endtask

`ifdef WB_RETIRE_COUNT_EN
   task automatic test_retire_count();
      do_reset();
      for (int k = 0; k < 17; k++) begin
         drive(1, 1, 5'(k + 1), 2'd0, 2'd0, 0, 32'(k), 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (retire_count !== TB_CNT_W'(1)) begin
         n_fail++; $display("FAIL retire_wrap: got %0d expected 1", retire_count);
      end
      drive(1, 1, 5'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
      tick();
      stall = 1;
      repeat (3) tick();
      stall = 0;
      n_checks++;
      if (retire_count !== TB_CNT_W'(1)) begin
         n_fail++; $display("FAIL retire_stalled: got %0d expected 1", retire_count);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      n_checks++;
      if (retire_count !== TB_CNT_W'(2)) begin
         n_fail++; $display("FAIL retire_bubble: got %0d expected 2", retire_count);
      end
   endtask
`endif

   initial begin
      model_clear();
      test_reset();
      test_alu();
      test_load();
      test_wen_and_sel();
      test_stall_flush();
      test_random();
`ifdef WB_RETIRE_COUNT_EN
      test_retire_count();
`endif
      test_halt();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
